// File: rtl/decode_queue_if.sv
// ---------------------------------------------------------------------------
// decode_queue_if
//
// Purpose: bundles the fetch-side and execute-side handshakes of the
// decode queue, together with the decoded head fields, into one interface.
//
// Signals:
//   in_valid / in_ready / in_instr / in_pc   fetch -> queue handshake
//   out_valid / out_ready / out_pc           queue -> execute handshake
//   out_alu_op, out_alu2_op                  ALU / shift-compare selects
//   out_alt_op, out_alt2_op                  SUB / arithmetic-shift modifiers
//   out_ra, out_rb, out_rd                   register indices
//   out_alu2_sel                             result from shift/compare unit
//   out_sel_pc_a, out_swap_imm_b             operand selects
//   out_mem, out_mem_read                    memory access, load vs store
//   out_branch, out_uncond, out_eq_cmp,
//   out_inv_cmp                              branch controls
//   out_illegal                              unsupported encoding
//
// Modports:
//   slave  - the queue itself
//   master - the environment (fetch + execute)
// ---------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [1:0]          out_alu_op;
  logic [1:0]          out_alu2_op;
  logic                out_alt_op;
  logic                out_alt2_op;
  logic [4:0]          out_ra;
  logic [4:0]          out_rb;
  logic [4:0]          out_rd;
  logic                out_alu2_sel;
  logic                out_sel_pc_a;
  logic                out_swap_imm_b;
  logic                out_mem;
  logic                out_mem_read;
  logic                out_branch;
  logic                out_uncond;
  logic                out_eq_cmp;
  logic                out_inv_cmp;
  logic                out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output out_alu_op, out_alu2_op, out_alt_op, out_alt2_op,
    output out_ra, out_rb, out_rd,
    output out_alu2_sel, out_sel_pc_a, out_swap_imm_b,
    output out_mem, out_mem_read,
    output out_branch, out_uncond, out_eq_cmp, out_inv_cmp,
    output out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_alu_op, out_alu2_op, out_alt_op, out_alt2_op,
    input  out_ra, out_rb, out_rd,
    input  out_alu2_sel, out_sel_pc_a, out_swap_imm_b,
    input  out_mem, out_mem_read,
    input  out_branch, out_uncond, out_eq_cmp, out_inv_cmp,
    input  out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
//
// Purpose: decode stage for the RV32I core. Fetched instructions and their
// PCs are buffered in a DEPTH-entry circular queue; the head entry's decoded
// control fields are presented from registers. A synchronous flush discards
// every entry (taken branch).
//
// Parameters:
//   DEPTH     queue entries, power of two, >= 2
//   PC_WIDTH  width of the carried PC
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   flush  discard all entries (priority over push and pop)
//   count  occupied entries, 0..DEPTH
//   bus    decode_queue_if.slave: fetch handshake in, decoded head out
//
// Configuration:
//   DECODE_QUEUE_ILLEGAL_EN  when defined, out_illegal flags encodings outside
//                            the supported RV32I opcode set and suppresses
//                            their memory/branch/shift-compare controls. When
//                            undefined, out_illegal is tied to 0.
// ---------------------------------------------------------------------------
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  decode_queue_if.slave            bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // funct3 values served by the shift/compare unit: SLL, SLT, SLTU, SRL/SRA
  localparam logic [7:0]  SHIFT_CMP_MAP = 8'b00101110;
  // operand-B immediate swap, indexed by {i[5:4], i[2], shift/compare}
  localparam logic [15:0] SWAP_MAP      = 16'b1110111111010011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu2_op;
    logic       alt_op;
    logic       alt2_op;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
    logic       alu2_sel;
    logic       sel_pc_a;
    logic       swap_imm_b;
    logic       mem;
    logic       mem_read;
    logic       branch;
    logic       uncond;
    logic       eq_cmp;
    logic       inv_cmp;
    logic       illegal;
  } ctrl_t;

  // Pure combinational decode of one instruction word into control fields.
  function automatic ctrl_t decode(input logic [31:0] i);
    ctrl_t      c;
    logic [2:0] f3;
    logic       compute;
    logic       r;
    logic       j;
    logic       b;
    logic       lui;
    logic       l_bit;

    f3      = i[14:12];
    compute = ({i[6], i[4:2]} == 4'b0100);
    r       = (i[6:2] == 5'b01100);
    j       = i[6] & i[2];
    b       = i[6] & (i[4:2] == 3'b000);
    lui     = ({i[6:4], i[2]} == 4'b0111);
    l_bit   = SHIFT_CMP_MAP[f3];

    c.alu_op     = compute ? {f3[2] ^ f3[0], f3[1]} : 2'b00;
    c.alu2_op    = compute ? {f3[2], f3[1]} : {1'b0, b};
    c.alt_op     = r & i[30];
    c.alt2_op    = compute & i[30];
    c.ra         = lui ? 5'd0 : i[19:15];
    c.rb         = i[24:20];
    c.rd         = i[11:7];
    c.alu2_sel   = compute ? l_bit : 1'b0;
    c.mem        = ({i[6], i[4:2]} == 4'b0000);
    c.mem_read   = ~i[5];
    c.branch     = j | b;
    c.uncond     = j;
    c.eq_cmp     = ~f3[2];
    c.inv_cmp    = f3[0];
    c.sel_pc_a   = (i[6] & i[5] & (i[2] == i[3])) |
                   (~i[6] & ~i[5] & (i[2] != i[3]));
    c.swap_imm_b = SWAP_MAP[{i[5:4], i[2], l_bit}];

`ifdef DECODE_QUEUE_ILLEGAL_EN
    c.illegal = (i[1:0] != 2'b11) ||
                !(i[6:0] inside {7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b1100011});
    // an illegal word must never start a memory access, redirect fetch or
    // steer the result mux
    if (c.illegal) begin
      c.mem      = 1'b0;
      c.branch   = 1'b0;
      c.uncond   = 1'b0;
      c.alu2_sel = 1'b0;
    end
`else
    c.illegal = 1'b0;
`endif
    return c;
  endfunction

  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                valid_q;
  ctrl_t               ctrl_q;
  logic [PC_WIDTH-1:0] pc_q;

  logic                push;
  logic                pop;
  logic [PTR_W-1:0]    next_rd_ptr;
  logic                bypass;
  logic [31:0]         head_instr;
  logic [PC_WIDTH-1:0] head_pc;
  logic [CNT_W-1:0]    next_count;

  // in_ready depends only on the registered count, so there is no path
  // from out_ready; a full queue refuses a push even if it pops that cycle
  assign bus.in_ready = (count != FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = valid_q & bus.out_ready;

  // The decoded registers are loaded with the entry that is head next cycle.
  // That entry is the one being written right now only when the queue is
  // (or is about to become) empty; it has not reached storage yet, so it is
  // forwarded straight from the input.
  always_comb begin
    next_rd_ptr = rd_ptr;
    if (pop) begin
      next_rd_ptr = rd_ptr + PTR_W'(1);
    end
    bypass     = push & (next_rd_ptr == wr_ptr);
    head_instr = bypass ? bus.in_instr : instr_mem[next_rd_ptr];
    head_pc    = bypass ? bus.in_pc    : pc_mem[next_rd_ptr];
  end

  // Occupancy update; flush wins over any push or pop in the same cycle.
  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else if (push && !pop) begin
      next_count = count + CNT_W'(1);
    end else if (pop && !push) begin
      next_count = count - CNT_W'(1);
    end
  end

  // Entry storage. Cleared on reset so the head decode never sees X, even
  // when it reads a slot that was never written. A flush-cycle push is
  // dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        instr_mem[k] <= '0;
        pc_mem[k]    <= '0;
      end
    end else if (push && !flush) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  // Pointers and occupancy. Pointers are PTR_W bits wide, so wrapping from
  // DEPTH-1 to 0 falls out of the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= next_rd_ptr;
      count   <= next_count;
      valid_q <= (next_count != '0);
    end
  end

  // Head decode registers. Reloaded every cycle; while execute stalls the
  // head pointer does not move and no write lands on the head slot, so the
  // fields stay stable. During a flush they may take any value because
  // out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      pc_q   <= '0;
    end else begin
      ctrl_q <= decode(head_instr);
      pc_q   <= head_pc;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_alu_op     = ctrl_q.alu_op;
  assign bus.out_alu2_op    = ctrl_q.alu2_op;
  assign bus.out_alt_op     = ctrl_q.alt_op;
  assign bus.out_alt2_op    = ctrl_q.alt2_op;
  assign bus.out_ra         = ctrl_q.ra;
  assign bus.out_rb         = ctrl_q.rb;
  assign bus.out_rd         = ctrl_q.rd;
  assign bus.out_alu2_sel   = ctrl_q.alu2_sel;
  assign bus.out_sel_pc_a   = ctrl_q.sel_pc_a;
  assign bus.out_swap_imm_b = ctrl_q.swap_imm_b;
  assign bus.out_mem        = ctrl_q.mem;
  assign bus.out_mem_read   = ctrl_q.mem_read;
  assign bus.out_branch     = ctrl_q.branch;
  assign bus.out_uncond     = ctrl_q.uncond;
  assign bus.out_eq_cmp     = ctrl_q.eq_cmp;
  assign bus.out_inv_cmp    = ctrl_q.inv_cmp;
  assign bus.out_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
//
// Purpose: self-checking bench for decode_queue. A queue of {instr, pc}
// entries plus an instruction-level decode function act as the reference;
// every cycle the DUT's count, handshakes, head PC and decoded fields are
// compared against it.
// ---------------------------------------------------------------------------
module tb_decode_queue;

  localparam int DEPTH    = 4;
  localparam int PC_WIDTH = 32;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;

  decode_queue_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .count (count),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  entry_t model_q[$];
  int     checks = 0;
  int     fails  = 0;

  logic [6:0] legal_ops [9] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37,
                                7'h17, 7'h6F, 7'h67, 7'h63};

  logic [30:0] dut_fields;
  assign dut_fields = {bus.out_alu_op, bus.out_alu2_op, bus.out_alt_op,
                       bus.out_alt2_op, bus.out_ra, bus.out_rb, bus.out_rd,
                       bus.out_alu2_sel, bus.out_sel_pc_a, bus.out_swap_imm_b,
                       bus.out_mem, bus.out_mem_read, bus.out_branch,
                       bus.out_uncond, bus.out_eq_cmp, bus.out_inv_cmp,
                       bus.out_illegal};

  // Reference decode, reasoned per instruction class with integer arithmetic.
  function automatic logic [30:0] ref_decode(input logic [31:0] i);
    int   f3, lbit, idx, b5, b4, b2;
    bit   arith, reg_op, jump, cbr, lui, bad;
    bit   mem, br, unc, sel2, spa;
    logic [1:0] aop, a2op;
    logic [4:0] ra;

    f3     = int'(i[14:12]);
    arith  = (i[6] == 1'b0) && (i[4:2] == 3'b100);
    reg_op = (i[6:2] == 5'b01100);
    jump   = i[6] && i[2];
    cbr    = i[6] && (i[4:2] == 3'b000);
    lui    = (i[6:4] == 3'b011) && i[2];
    lbit   = (32'h2E >> f3) & 1;
    b5     = int'(i[5]);
    b4     = int'(i[4]);
    b2     = int'(i[2]);
    idx    = b5 * 8 + b4 * 4 + b2 * 2 + lbit;

    aop  = arith ? 2'(((f3 >> 2) ^ (f3 & 1)) * 2 + ((f3 >> 1) & 1)) : 2'd0;
    a2op = arith ? 2'(f3 >> 1) : (cbr ? 2'd1 : 2'd0);
    ra   = lui ? 5'd0 : i[19:15];
    sel2 = arith && (lbit == 1);
    mem  = (i[6] == 1'b0) && (i[4:2] == 3'b000);
    br   = jump || cbr;
    unc  = jump;
    spa  = (i[6] && i[5] && (i[2] == i[3])) || (!i[6] && !i[5] && (i[2] != i[3]));
    bad  = 1'b0;
`ifdef DECODE_QUEUE_ILLEGAL_EN
    bad = !(i[6:0] inside {7'h03, 7'h23, 7'h13, 7'h33, 7'h37,
                           7'h17, 7'h6F, 7'h67, 7'h63});
    if (bad) begin
      mem  = 1'b0;
      br   = 1'b0;
      unc  = 1'b0;
      sel2 = 1'b0;
    end
`endif
    return {aop, a2op, reg_op && i[30], arith && i[30], ra, i[24:20], i[11:7],
            sel2, spa, 1'((32'hEFD3 >> idx) & 1), mem, !i[5], br, unc,
            f3 < 4, 1'(f3 & 1), bad};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) != 0) begin
      w[6:0] = legal_ops[$urandom_range(0, 8)];
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkQueue();
    int n;
    n = model_q.size();
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(n != 0));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(n < DEPTH));
    checkOutput("fields_known", 64'($isunknown(dut_fields)), 64'(0));
    if (n > 0) begin
      checkOutput("out_pc", 64'(bus.out_pc), 64'(model_q[0].pc));
      checkOutput("fields", 64'(dut_fields), 64'(ref_decode(model_q[0].instr)));
    end
  endtask

  // One clock cycle: drive, advance the reference at the edge, then compare.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [PC_WIDTH-1:0] pc,
                               input logic ready, input logic fl);
    bit do_pop, do_push;
    bus.in_valid  = valid;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ready;
    flush         = fl;
    do_pop  = (model_q.size() > 0) && ready;
    do_push = valid && (model_q.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: instr, pc: pc});
    end
    #1;
    checkQueue();
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("rst_fields", 64'(dut_fields), 64'(0));
    checkOutput("rst_out_pc", 64'(bus.out_pc), 64'(0));
    rst = 1'b0;

    $display("[TB] ADDI single push");
    applyStimulus(1'b1, 32'h00510093, 32'h100, 1'b0, 1'b0);
    checkOutput("addi_valid", 64'(bus.out_valid), 64'(1));
    checkOutput("addi_ra", 64'(bus.out_ra), 64'(2));
    checkOutput("addi_rb", 64'(bus.out_rb), 64'(5));
    checkOutput("addi_rd", 64'(bus.out_rd), 64'(1));
    checkOutput("addi_alu_op", 64'(bus.out_alu_op), 64'(0));
    checkOutput("addi_alu2_sel", 64'(bus.out_alu2_sel), 64'(0));
    checkOutput("addi_pc", 64'(bus.out_pc), 64'(32'h100));

    $display("[TB] fill to full and refuse");
    for (int k = 1; k < DEPTH; k++) begin
      applyStimulus(1'b1, rand_instr(), 32'h100 + 32'(4 * k), 1'b0, 1'b0);
    end
    checkOutput("full_count", 64'(count), 64'(DEPTH));
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'(0));
    applyStimulus(1'b1, rand_instr(), 32'h1F0, 1'b0, 1'b0);
    checkOutput("refused_count", 64'(count), 64'(DEPTH));
    applyStimulus(1'b1, rand_instr(), 32'h1F4, 1'b1, 1'b0);
    checkOutput("full_pushpop_count", 64'(count), 64'(DEPTH - 1));
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    $display("[TB] streaming with wrap");
    for (int k = 0; k < 3 * DEPTH; k++) begin
      applyStimulus(1'b1, rand_instr(), 32'h200 + 32'(4 * k), 1'b1, 1'b0);
      if (k > 0) begin
        checkOutput("stream_no_bubble", 64'(bus.out_valid), 64'(1));
      end
    end
    checkOutput("stream_last_pc", 64'(bus.out_pc), 64'(32'h200 + 4 * (3 * DEPTH - 1)));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] SLLI and BEQ");
    applyStimulus(1'b1, 32'h00119193, 32'h300, 1'b0, 1'b0);
    checkOutput("slli_alu2_sel", 64'(bus.out_alu2_sel), 64'(1));
    checkOutput("slli_alu2_op", 64'(bus.out_alu2_op), 64'(0));
    applyStimulus(1'b1, 32'h00208463, 32'h304, 1'b1, 1'b0);
    checkOutput("beq_branch", 64'(bus.out_branch), 64'(1));
    checkOutput("beq_uncond", 64'(bus.out_uncond), 64'(0));
    checkOutput("beq_eq_cmp", 64'(bus.out_eq_cmp), 64'(1));
    checkOutput("beq_alu2_op", 64'(bus.out_alu2_op), 64'(1));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] flush with in_valid");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, rand_instr(), 32'h400 + 32'(4 * k), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, rand_instr(), 32'h999, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(count), 64'(0));
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'(0));
    applyStimulus(1'b1, 32'h00510093, 32'h500, 1'b0, 1'b0);
    checkOutput("post_flush_pc", 64'(bus.out_pc), 64'(32'h500));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] unsupported encoding");
    applyStimulus(1'b1, 32'h0000000B, 32'h600, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_ILLEGAL_EN
    checkOutput("illegal_flag", 64'(bus.out_illegal), 64'(1));
`else
    checkOutput("illegal_flag", 64'(bus.out_illegal), 64'(0));
`endif
    checkOutput("illegal_mem", 64'(bus.out_mem), 64'(0));
    checkOutput("illegal_branch", 64'(bus.out_branch), 64'(0));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), rand_instr(),
                    32'h1000 + 32'(4 * k), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, rand_instr(), 32'h2000, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_instr(), 32'h2004, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_q.delete();
    checkOutput("midrst_count", 64'(count), 64'(0));
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("midrst_fields", 64'(dut_fields), 64'(0));
    checkOutput("midrst_pc", 64'(bus.out_pc), 64'(0));
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'h00119193, 32'h2100, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
